audio_pwm_out: RTL and testbench

- Consumes the 16-bit signed mic sample stream (data_mic / data_mic_valid strobe, about 48 kHz) produced by the mic capture stage.
- Buffers samples in a small FIFO and drives the board mono audio amplifier through single-bit PWM (aud_pwm_o) plus an amp enable (aud_sd_o).
- Provides mic-to-speaker loopback and playback-path status (fill level, sticky overflow and underflow flags).

---
 rtl/audio_pwm_out_pkg.sv | 22 ++
 rtl/audio_sample_fifo.sv | 60 ++++++
 rtl/audio_pwm_out.sv | 118 +++++++++++
 tb/tb_audio_pwm_out.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pwm_out_pkg.sv
// Shared state type, midscale constant and sample-to-duty conversion
// for the mono audio PWM playback path.
package audio_pwm_out_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } play_state_e;

  // Midscale in 16-bit offset binary; users keep the top PWM_BITS bits.
  localparam logic [15:0] PWM_MID = 16'h8000;

  // Attenuate a signed sample, then flip the sign bit to get offset binary.
  function automatic logic [15:0] sample_to_offset(input logic signed [15:0] sample,
                                                   input logic        [2:0]  vol_shift);
    logic signed [15:0] t;
    t = sample >>> vol_shift;
    return {~t[15], t[14:0]};
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with occupancy count and a synchronous flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module audio_sample_fifo
  import audio_pwm_out_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign wr_en   = push && (!full || pop);
  assign rd_en   = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and level
  // define which entries are valid, and a reset-free array maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_en) - LW'(rd_en);
    end
  end

endmodule

// File: rtl/audio_pwm_out.sv
// Mic-to-speaker loopback: buffers 16-bit samples and plays them as a
// single-bit PWM stream, with priming, starvation handling and sticky status.
module audio_pwm_out
  import audio_pwm_out_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PWM_BITS   = 10,
  parameter int STARVE_MAX = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          data_mic_valid_i,
  input  logic [15:0]                   data_mic_i,
  input  logic [2:0]                    vol_shift_i,
  input  logic                          clr_status_i,
  output logic                          aud_pwm_o,
  output logic                          aud_sd_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          underflow_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [PWM_BITS-1:0] DUTY_MID = PWM_BITS'(PWM_MID >> (16 - PWM_BITS));

  play_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q, duty_d, new_duty;
  logic [SW-1:0]       starve_q, starve_d;
  logic                boundary, push, pop, ovf_set, uf_set, aud_pwm_d;
  logic [15:0]         fifo_rd_data;
  logic                fifo_full, fifo_empty;

  assign boundary = (pwm_cnt == '0);
  assign push     = data_mic_valid_i && enable_i;
  assign pop      = enable_i && (state_q == PLAY) && boundary && !fifo_empty;
  assign ovf_set  = push && fifo_full && !pop;
  assign new_duty = PWM_BITS'(sample_to_offset(fifo_rd_data, vol_shift_i) >> (16 - PWM_BITS));

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush   (!enable_i),
    .push    (push),
    .pop     (pop),
    .wr_data (data_mic_i),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level_o)
  );

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    starve_d = starve_q;
    uf_set   = 1'b0;
    if (!enable_i) begin
      state_d  = IDLE;
      duty_d   = DUTY_MID;
      starve_d = '0;
    end else begin
      unique case (state_q)
        IDLE:  state_d = PRIME;
        PRIME: if (boundary && fifo_level_o >= LW'(FIFO_DEPTH / 2)) state_d = PLAY;
        PLAY: begin
          if (boundary) begin
            if (!fifo_empty) begin
              duty_d   = new_duty;
              starve_d = '0;
            end else if (starve_q == SW'(STARVE_MAX - 1)) begin
              uf_set   = 1'b1;
              duty_d   = DUTY_MID;
              starve_d = '0;
              state_d  = PRIME;
            end else begin
              starve_d = starve_q + SW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Compare against the duty being loaded so a new value lands in its own period.
  assign aud_pwm_d = (state_d != IDLE) && (pwm_cnt < duty_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pwm_cnt     <= '0;
      duty_q      <= DUTY_MID;
      starve_q    <= '0;
      aud_pwm_o   <= 1'b0;
      aud_sd_o    <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwm_cnt     <= pwm_cnt + PWM_BITS'(1);
      duty_q      <= duty_d;
      starve_q    <= starve_d;
      aud_pwm_o   <= aud_pwm_d;
      aud_sd_o    <= (state_d != IDLE);
      overflow_o  <= ovf_set | (overflow_o & ~clr_status_i);
      underflow_o <= uf_set  | (underflow_o & ~clr_status_i);
    end
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out: duty table, multi-cycle corner
// sequences and random traffic, all compared against a queue-based model.
module tb_audio_pwm_out;

  localparam int PERIOD = 1024;
  localparam int DEPTH  = 16;
  localparam int STARVE = 64;
  localparam int MID    = 512;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        data_mic_valid_i = 1'b0;
  logic [15:0] data_mic_i = '0;
  logic [2:0]  vol_shift_i = '0;
  logic        clr_status_i = 1'b0;
  logic        aud_pwm_o, aud_sd_o, overflow_o, underflow_o;
  logic [4:0]  fifo_level_o;

  always #5 clk_i = ~clk_i;

  audio_pwm_out dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .enable_i         (enable_i),
    .data_mic_valid_i (data_mic_valid_i),
    .data_mic_i       (data_mic_i),
    .vol_shift_i      (vol_shift_i),
    .clr_status_i     (clr_status_i),
    .aud_pwm_o        (aud_pwm_o),
    .aud_sd_o         (aud_sd_o),
    .fifo_level_o     (fifo_level_o),
    .overflow_o       (overflow_o),
    .underflow_o      (underflow_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_PRIME, M_PLAY} mode_e;
  mode_e       m_mode = M_IDLE;
  logic [15:0] m_q[$];
  int          m_cnt = 0, m_duty = MID, m_starve = 0;
  bit          m_ovf = 0, m_uf = 0, m_pwm = 0, m_sd = 0, m_last_bnd = 0;

  function automatic int ref_duty(input logic [15:0] s, input int sh);
    int v, d, t;
    v = int'($signed(s));
    d = 1 << sh;
    t = v / d;
    if (v < 0 && t * d != v) t = t - 1;   // floor division
    return (t + 32768) / 64;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_q.delete(); m_cnt = 0; m_duty = MID; m_starve = 0;
    m_ovf = 0; m_uf = 0; m_pwm = 0; m_sd = 0; m_last_bnd = 0;
  endfunction

  function automatic void model_step();
    int  c, lvl;
    bit  bnd, pop, push_ok, ovf_set, uf_set;
    c = m_cnt; bnd = (c == 0); lvl = m_q.size();
    pop = 0; push_ok = 0; ovf_set = 0; uf_set = 0;
    if (!enable_i) begin
      m_q.delete(); m_mode = M_IDLE; m_duty = MID; m_starve = 0;
    end else begin
      pop = (m_mode == M_PLAY) && bnd && (lvl > 0);
      if (data_mic_valid_i) begin
        if (lvl < DEPTH || pop) push_ok = 1;
        else ovf_set = 1;
      end
      case (m_mode)
        M_IDLE:  m_mode = M_PRIME;
        M_PRIME: if (bnd && lvl >= DEPTH / 2) m_mode = M_PLAY;
        default: if (bnd) begin
          if (pop) begin
            m_duty = ref_duty(m_q.pop_front(), int'(vol_shift_i));
            m_starve = 0;
          end else begin
            m_starve++;
            if (m_starve == STARVE) begin
              uf_set = 1; m_duty = MID; m_mode = M_PRIME; m_starve = 0;
            end
          end
        end
      endcase
      if (push_ok) m_q.push_back(data_mic_i);
    end
    m_ovf = ovf_set | (m_ovf & ~clr_status_i);
    m_uf  = uf_set  | (m_uf  & ~clr_status_i);
    m_sd  = (m_mode != M_IDLE);
    m_pwm = (m_mode != M_IDLE) && (c < m_duty);
    m_cnt = (c + 1) % PERIOD;
    m_last_bnd = bnd;
  endfunction

  // One clock: advance the model with pre-edge inputs, then compare #1 later.
  task automatic tick();
    @(posedge clk_i);
    if (!rst_ni) model_reset(); else model_step();
    #1;
    check("lockstep", 32'({aud_pwm_o, aud_sd_o, fifo_level_o, overflow_o, underflow_o}),
          32'({m_pwm, m_sd, 5'(m_q.size()), m_ovf, m_uf}));
  endtask

  task automatic wait_boundary();
    int n = 0;
    do begin tick(); n++; end while (!m_last_bnd && n < 2 * PERIOD + 4);
    if (!m_last_bnd) check("boundary_timeout", 32'(0), 32'(1));
  endtask

  // Count PWM highs from the current (boundary) tick over one full period.
  task automatic measure(output int highs);
    highs = int'(aud_pwm_o);
    repeat (PERIOD - 1) begin tick(); highs += int'(aud_pwm_o); end
  endtask

  task automatic push_sample(input logic [15:0] s);
    data_mic_i = s; data_mic_valid_i = 1'b1; tick(); data_mic_valid_i = 1'b0;
  endtask

  typedef struct { logic [15:0] sample; logic [2:0] shift; int duty; } vec_t;
  vec_t vecs[13];

  initial begin
    int h;
    for (int i = 0; i < 8; i++) vecs[i] = '{16'h0000, 3'(i), 512};
    vecs[8]  = '{16'h7FFF, 3'd0, 1023};
    vecs[9]  = '{16'h8000, 3'd0, 0};
    vecs[10] = '{16'h7FFF, 3'd1, 767};
    vecs[11] = '{16'h8000, 3'd7, 508};
    vecs[12] = '{16'hFFFF, 3'd0, 511};

    // Reset state
    repeat (3) tick();
    check("reset_outputs", 32'({aud_pwm_o, aud_sd_o, fifo_level_o, overflow_o, underflow_o}), 32'(0));
    rst_ni = 1'b1;
    tick();

    // Priming: 8 midscale samples plus the duty table samples
    enable_i = 1'b1;
    for (int i = 0; i < 13; i++) push_sample(vecs[i].sample);
    check("prime_level", 32'(fifo_level_o), 32'(13));
    check("prime_sd", 32'(aud_sd_o), 32'(1));
    wait_boundary();   // PRIME -> PLAY

    // Duty table: one sample popped per boundary, volume sampled at pop
    for (int i = 0; i < 13; i++) begin
      vol_shift_i = vecs[i].shift;
      wait_boundary();
      measure(h);
      check($sformatf("duty_vec%0d", i), 32'(h), 32'(vecs[i].duty));
    end
    vol_shift_i = '0;

    // Underflow after STARVE empty boundaries
    repeat (STARVE - 1) wait_boundary();
    check("underflow_not_yet", 32'(underflow_o), 32'(0));
    wait_boundary();
    check("underflow_set", 32'(underflow_o), 32'(1));
    check("underflow_sd", 32'(aud_sd_o), 32'(1));
    measure(h);
    check("underflow_mid_duty", 32'(h), 32'(MID));

    // Overflow: 20 back-to-back pushes starting at pwm_cnt=1 in PRIME
    tick();
    for (int i = 0; i < 20; i++) begin
      data_mic_i = 16'($urandom); data_mic_valid_i = 1'b1; tick();
    end
    data_mic_valid_i = 1'b0;
    check("overflow_level", 32'(fifo_level_o), 32'(16));
    check("overflow_set", 32'(overflow_o), 32'(1));
    clr_status_i = 1'b1; tick(); clr_status_i = 1'b0;
    check("overflow_cleared", 32'(overflow_o), 32'(0));
    check("underflow_cleared", 32'(underflow_o), 32'(0));

    // Disable mid-play with 10 queued samples
    enable_i = 1'b0; tick(); enable_i = 1'b1;
    check("flush_level", 32'(fifo_level_o), 32'(0));
    for (int i = 0; i < 10; i++) push_sample(16'($urandom));
    wait_boundary();
    check("play_level", 32'(fifo_level_o), 32'(10));
    enable_i = 1'b0; data_mic_valid_i = 1'b1; data_mic_i = 16'($urandom);
    tick();
    check("disable_outputs", 32'({aud_pwm_o, aud_sd_o, fifo_level_o}), 32'(0));
    repeat (3) tick();
    check("disabled_push_ignored", 32'(fifo_level_o), 32'(0));
    data_mic_valid_i = 1'b0;

    // Random traffic against the model
    enable_i = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      data_mic_valid_i = ($urandom_range(0, 15) == 0);
      data_mic_i       = 16'($urandom);
      vol_shift_i      = 3'($urandom);
      clr_status_i     = ($urandom_range(0, 199) == 0);
      enable_i         = ($urandom_range(0, 999) != 0);
      tick();
    end
    data_mic_valid_i = 1'b0; clr_status_i = 1'b0;

    // Async reset mid-PLAY
    enable_i = 1'b0; tick(); enable_i = 1'b1;
    for (int i = 0; i < 8; i++) push_sample(16'($urandom));
    wait_boundary();
    repeat (5) tick();
    check("pre_reset_sd", 32'(aud_sd_o), 32'(1));
    #3 rst_ni = 1'b0;
    model_reset();
    #1;
    check("async_reset", 32'({aud_pwm_o, aud_sd_o, fifo_level_o, overflow_o, underflow_o}), 32'(0));
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    check("pwm_restart", 32'(aud_pwm_o), 32'(1));
    measure(h);
    check("restart_mid_duty", 32'(h), 32'(MID));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
